// File: rtl/bidir_sr_pkg.sv
// Shared types and helpers for the bidirectional shift-register sequencer.
// Holds the FSM state enum, the length-field width derivation and the length clamp.
package bidir_sr_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StSettle,
      StResp
   } sr_ctrl_state_t;

   localparam int unsigned DefaultWidth = 8;

   // Length field must be able to encode WIDTH itself, hence the extra bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return 32'($clog2(width)) + 32'd1;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
      return (len > width) ? width : len;
   endfunction

endpackage

// File: rtl/sr_shift_cnt.sv
// Loadable down-counter tracking the shifts remaining in the current job.
// Flags the final shift so the controller can leave SHIFT on time.
module sr_shift_cnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/bidir_sr_ctrl.sv
// Command-driven sequencer for a bidirectional serial-in shift register: shifts a
// job's bits in over sr_en/sr_dir/sr_d, then returns the register's parallel output.
module bidir_sr_ctrl
   import bidir_sr_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_len,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             sr_en,
   output logic             sr_dir,
   output logic             sr_d,
   input  logic [WIDTH-1:0] sr_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   sr_ctrl_state_t state_q, state_d;

   logic [WIDTH-1:0] buf_q, buf_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             sr_en_q, sr_en_d;
   logic             sr_dir_q, sr_dir_d;
   logic             sr_d_q, sr_d_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;

   logic [CNT_W-1:0] len_clamped;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_last;

   assign len_clamped = CNT_W'(clamp_len(32'(cmd_len), WIDTH));

   sr_shift_cnt #(
      .CNT_W (CNT_W)
   ) u_shift_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (len_clamped),
      .dec      (cnt_dec),
      .last     (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      sr_dir_d   = sr_dir_q;
      rsp_data_d = rsp_data_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               buf_d    = cmd_data;
               sr_dir_d = cmd_dir;
               cnt_load = 1'b1;
               state_d  = (len_clamped != '0) ? StShift : StSettle;
            end
         end
         StShift: begin
            buf_d   = buf_q >> 1;
            cnt_dec = 1'b1;
            if (cnt_last) begin
               state_d = StSettle;
            end
         end
         StSettle: begin
            rsp_data_d = sr_out;
            state_d    = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      sr_en_d     = (state_d == StShift);
      sr_d_d      = (state_d == StShift) && buf_d[0];
      rsp_valid_d = (state_d == StResp);
      busy_d      = (state_d != StIdle);
      cmd_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         buf_q       <= '0;
         rsp_data_q  <= '0;
         cmd_ready_q <= 1'b1;
         sr_en_q     <= 1'b0;
         sr_dir_q    <= 1'b0;
         sr_d_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         rsp_data_q  <= rsp_data_d;
         cmd_ready_q <= cmd_ready_d;
         sr_en_q     <= sr_en_d;
         sr_dir_q    <= sr_dir_d;
         sr_d_q      <= sr_d_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign sr_en     = sr_en_q;
   assign sr_dir    = sr_dir_q;
   assign sr_d      = sr_d_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bidir_sr_ctrl.sv
// Scoreboard bench for bidir_sr_ctrl driving a behavioral 8-bit bidirectional shift register.
// Stimulus pushes expected responses; a negedge monitor checks timing, direction and data.
module tb_bidir_sr_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_dir;
   logic [CW-1:0] cmd_len;
   logic [W-1:0]  cmd_data;
   logic          sr_en;
   logic          sr_dir;
   logic          sr_d;
   logic [W-1:0]  sr_out;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data;
   logic          busy;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  len;
      logic         dir;
   } exp_t;

   exp_t         exp_q[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           acc_cyc = 0;
   int           hs_cyc = 0;
   int           en_cnt = 0;
   int           acc_first = 0;
   logic         prev_valid = 1'b0;
   logic [W-1:0] held = '0;
   logic [W-1:0] model_q = '0;

   bidir_sr_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .sr_en     (sr_en),
      .sr_dir    (sr_dir),
      .sr_d      (sr_d),
      .sr_out    (sr_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sr_en) begin
         model_q <= sr_dir ? {sr_d, model_q[W-1:1]} : {model_q[W-2:0], sr_d};
      end
   end
   assign sr_out = model_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got no event, want event", name);
   endtask

   task automatic start_cmd(input logic dir, input int unsigned len, input logic [W-1:0] data,
                            input logic [W-1:0] exp);
      exp_t e;
      e.data = exp;
      e.len  = (len > W) ? W : len;
      e.dir  = dir;
      exp_q.push_back(e);
      cmd_dir   = dir;
      cmd_len   = CW'(len);
      cmd_data  = data;
      cmd_valid = 1'b1;
   endtask

   task automatic wait_accept();
      int i = 0;
      while (!cmd_ready && i < 60) begin
         @(posedge clk); #1;
         i++;
      end
      if (!cmd_ready) begin
         fail("cmd_accept_timeout");
         cmd_valid = 1'b0;
         exp_q.delete();
      end else begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_rsp();
      int i = 0;
      while (!rsp_valid && i < 60) begin
         @(posedge clk); #1;
         i++;
      end
      if (!rsp_valid) fail("rsp_timeout");
   endtask

   task automatic wait_drain();
      int i = 0;
      while (exp_q.size() != 0 && i < 60) begin
         @(posedge clk); #1;
         i++;
      end
      if (exp_q.size() != 0) begin
         fail("drain_timeout");
         exp_q.delete();
      end
   endtask

   task automatic run_job(input logic dir, input int unsigned len, input logic [W-1:0] data,
                          input logic [W-1:0] exp);
      start_cmd(dir, len, data, exp);
      wait_accept();
      wait_drain();
   endtask

   // Monitor: latency, enable-cycle count, direction, data and stability under backpressure.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
            en_cnt     = 0;
         end else begin
            if (cmd_valid && cmd_ready) begin
               acc_cyc = cyc;
               en_cnt  = 0;
            end
            if (sr_en) begin
               en_cnt++;
               if (exp_q.size() != 0) check("sr_dir", 32'(sr_dir), 32'(exp_q[0].dir));
            end
            if (rsp_valid && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  fail("rsp_unexpected");
               end else begin
                  check("rsp_latency", 32'(cyc - acc_cyc), exp_q[0].len + 32'd2);
                  check("sr_en_cycles", 32'(en_cnt), exp_q[0].len);
                  check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
               end
               held = rsp_data;
            end else if (rsp_valid) begin
               check("rsp_stable", 32'(rsp_data), 32'(held));
            end
            if (rsp_valid && rsp_ready) begin
               hs_cyc = cyc;
               if (exp_q.size() != 0) exp_q.delete(0);
            end
            prev_valid = rsp_valid;
         end
      end
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_dir   = 1'b0;
      cmd_len   = '0;
      cmd_data  = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_sr_en", 32'(sr_en), 32'd0);
      check("rst_sr_dir", 32'(sr_dir), 32'd0);
      check("rst_sr_d", 32'(sr_d), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_job(1'b0, 8, 8'hB2, 8'h4D);   // left: bit 0 ends up at the top
      run_job(1'b1, 8, 8'hB2, 8'hB2);   // right: fully overwrites
      run_job(1'b0, 8, 8'h00, 8'h00);   // clear
      run_job(1'b0, 3, 8'h07, 8'h07);
      run_job(1'b0, 0, 8'h5A, 8'h07);   // no shift, data ignored
      run_job(1'b0, 12, 8'hFF, 8'hFF);  // clamps to 8

      // Backpressure with the next command held.
      rsp_ready = 1'b0;
      start_cmd(1'b1, 2, 8'h01, 8'h7F);
      wait_accept();
      start_cmd(1'b0, 1, 8'h00, 8'hFE);
      wait_rsp();
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      wait_accept();
      check("bp_accept_after_hs", 32'(acc_cyc), 32'(hs_cyc + 1));
      wait_drain();

      // Reset during the 4th shift cycle abandons the job.
      start_cmd(1'b0, 8, 8'hAA, 8'h00);
      wait_accept();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      check("rstmid_sr_en", 32'(sr_en), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < 15; i++) begin
         check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
         @(posedge clk); #1;
      end
      run_job(1'b0, 0, 8'h00, 8'hE5);   // four shifts of 0,1,0,1 landed before reset

      // Back-to-back throughput with rsp_ready high.
      start_cmd(1'b1, 4, 8'h0F, 8'hFE);
      wait_accept();
      acc_first = acc_cyc;
      start_cmd(1'b0, 0, 8'h00, 8'hFE);
      wait_accept();
      check("throughput", 32'(acc_cyc - acc_first), 32'd7);
      wait_drain();

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1, "global timeout");
   end

endmodule
